// File: rtl/rst_sequencer_if.sv
// Status and handshake signals between rst_sequencer and the blocks it sequences.
// The master modport is the sequencer. The slave modport is the network/SoC side.
interface rst_sequencer_if;
   logic       net_resetdone_i;
   logic       net_rst_o;
   logic       sys_rst_o;
   logic       sys_rst_n_o;
   logic       ready_o;
   logic       timeout_o;
   logic [1:0] state_o;

   modport master (
      input  net_resetdone_i,
      output net_rst_o,
      output sys_rst_o,
      output sys_rst_n_o,
      output ready_o,
      output timeout_o,
      output state_o
   );

   modport slave (
      output net_resetdone_i,
      input  net_rst_o,
      input  sys_rst_o,
      input  sys_rst_n_o,
      input  ready_o,
      input  timeout_o,
      input  state_o
   );
endinterface

// File: rtl/rst_sequencer.sv
// Power-on reset sequencer. It synchronises the release of the board reset and stretches
// the network reset. It waits for the network block's resetdone and then releases the SoC
// reset. On timeout it retries the network reset, and once the retries are used up it
// boots the SoC anyway with timeout_o set.
// Optional build macro RST_SEQ_RELOCK_EN: a loss of resetdone in RUN reruns the whole
// sequence. This only applies when RUN was reached without a timeout.
module rst_sequencer #(
   parameter int unsigned HOLD_CYCLES    = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 1048576,
   parameter int unsigned MAX_RETRIES    = 3,
   parameter int unsigned SYNC_STAGES    = 3
) (
   input  logic           sys_clk_i,
   input  logic           areset_i,
   rst_sequencer_if.master seq
);

   localparam int unsigned MaxCycles = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES
                                                                     : TIMEOUT_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
   localparam int unsigned RetryW    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   typedef enum logic [1:0] {
      StHold    = 2'd0,
      StNetWait = 2'd1,
      StRun     = 2'd2
   } state_e;

   logic [SYNC_STAGES-1:0] rst_sync_q;
   logic [SYNC_STAGES-1:0] done_sync_q;
   logic                   rst_sync;
   logic                   done_s;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [RetryW-1:0]      retry_q, retry_d;
   logic                   timeout_q, timeout_d;
   logic                   net_rst_q, net_rst_d;
   logic                   sys_rst_q, sys_rst_d;
   logic                   sys_rst_n_q, sys_rst_n_d;
   logic                   ready_q, ready_d;

   assign rst_sync = rst_sync_q[SYNC_STAGES-1];
   assign done_s   = done_sync_q[SYNC_STAGES-1];

   // Reset-release synchroniser: set asynchronously, releases after SYNC_STAGES edges.
   always_ff @(posedge sys_clk_i or posedge areset_i) begin
      if (areset_i) begin
         rst_sync_q <= '1;
      end else begin
         rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b0};
      end
   end

   // resetdone synchroniser from the network clock domain.
   always_ff @(posedge sys_clk_i or posedge areset_i) begin
      if (areset_i) begin
         done_sync_q <= '0;
      end else begin
         done_sync_q <= {done_sync_q[SYNC_STAGES-2:0], seq.net_resetdone_i};
      end
   end

   // Next-state logic: sequencing counter, retries and the registered output values.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      retry_d   = retry_q;
      timeout_d = timeout_q;

      case (state_q)
         StHold: begin
            if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
               state_d = StNetWait;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StNetWait: begin
            // A resetdone that arrives on the last timeout cycle still counts as success.
            if (done_s) begin
               state_d = StRun;
            end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               if (retry_q < RetryW'(MAX_RETRIES)) begin
                  retry_d = retry_q + RetryW'(1);
                  state_d = StHold;
                  cnt_d   = '0;
               end else begin
                  // Boot the SoC anyway so the UART is available for debug.
                  timeout_d = 1'b1;
                  state_d   = StRun;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StRun: begin
`ifdef RST_SEQ_RELOCK_EN
            if (!timeout_q && !done_s) begin
               state_d = StHold;
               cnt_d   = '0;
               retry_d = '0;
            end
`else
            state_d = StRun;
`endif
         end
         default: begin
            state_d = StHold;
            cnt_d   = '0;
         end
      endcase

      // Hold the sequence at its start until the release has been synchronised.
      if (rst_sync) begin
         state_d = StHold;
         cnt_d   = '0;
      end

      net_rst_d   = (state_d == StHold);
      sys_rst_d   = (state_d != StRun);
      sys_rst_n_d = (state_d == StRun);
      ready_d     = (state_d == StRun);
   end

   // State and output registers; areset_i forces the reset values without a clock.
   always_ff @(posedge sys_clk_i or posedge areset_i) begin
      if (areset_i) begin
         state_q     <= StHold;
         cnt_q       <= '0;
         retry_q     <= '0;
         timeout_q   <= 1'b0;
         net_rst_q   <= 1'b1;
         sys_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         timeout_q   <= timeout_d;
         net_rst_q   <= net_rst_d;
         sys_rst_q   <= sys_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
      end
   end

   assign seq.net_rst_o   = net_rst_q;
   assign seq.sys_rst_o   = sys_rst_q;
   assign seq.sys_rst_n_o = sys_rst_n_q;
   assign seq.ready_o     = ready_q;
   assign seq.timeout_o   = timeout_q;
   assign seq.state_o     = state_q;

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Power-on/reset sequencer between the board reset pin and the rest of the design; replaces the direct wiring of the pin to the system reset.
- Takes the raw reset and produces a synchronised, stretched reset for the QSFP network block.
- Waits for the network block's resetdone, then releases the SoC reset, retrying the network on timeout.
- Exposes its state for debug LEDs.

Parameters:
- HOLD_CYCLES, 1024: cycles both resets stay asserted after synchronised reset release; must be >= 1.
- TIMEOUT_CYCLES, 1048576: cycles to wait for network resetdone per attempt; must be >= 1.
- MAX_RETRIES, 3: network reset retries after a timeout before giving up.
- SYNC_STAGES, 3: flop depth of the reset-release and resetdone synchronisers; must be >= 2.

Ports:
- sys_clk_i  in  1  system clock.
- areset_i  in  1  asynchronous reset, active-high.
- net_resetdone_i  in  1  network resetdone; asynchronous to sys_clk_i.
- net_rst_o  out  1  reset to network block, active-high.
- sys_rst_o  out  1  reset to SoC, active-high.
- sys_rst_n_o  out  1  always ~sys_rst_o.
- ready_o  out  1  high in RUN.
- timeout_o  out  1  sticky: retries exhausted.
- state_o  out  2  FSM state: 0 HOLD, 1 NET_WAIT, 2 RUN.

Behaviour:
- Clock and reset (already decided): one clock, sys_clk_i; reset areset_i is asynchronous and active-high.
- While areset_i is high, all state is forced immediately, with no clock edge needed:
  - net_rst_o=1, sys_rst_o=1, sys_rst_n_o=0, ready_o=0, timeout_o=0, state_o=0.
  - Counter=0, retry count=0, both synchroniser chains in reset state.
- Reset release:
  - Internal rst_sync chain has SYNC_STAGES flops, asynchronously set by areset_i, shifting in 0.
  - Edge 1 is the first rising edge that samples areset_i low. rst_sync falls after edge SYNC_STAGES.
  - While rst_sync=1 the FSM is held in HOLD with counter=0.
- net_resetdone_i passes through a SYNC_STAGES-flop synchroniser (reset value 0) to give done_s. All decisions use done_s.
- All outputs are registered. State changes are visible on outputs after the edge on which the transition happens.
- HOLD:
  - net_rst_o=1, sys_rst_o=1.
  - Counter increments each edge once rst_sync=0.
  - At counter==HOLD_CYCLES-1: go to NET_WAIT and clear the counter.
  - So net_rst_o falls after edge SYNC_STAGES+HOLD_CYCLES on first release.
- NET_WAIT:
  - net_rst_o=0, sys_rst_o=1, counter increments.
  - If done_s=1: go to RUN. This has priority over timeout in the same cycle.
  - Else at counter==TIMEOUT_CYCLES-1:
    - If retry count < MAX_RETRIES: increment retry count, go to HOLD, clear counter. net_rst_o reasserts for HOLD_CYCLES.
    - Else: set timeout_o=1 and go to RUN, so the SoC/UART still boots for debug.
- RUN:
  - net_rst_o=0, sys_rst_o=0, ready_o=1. Counter frozen.
  - done_s falling is ignored, unless the optional feature is compiled in.
- HOLD is never shortcut by done_s. done_s already high on entry to NET_WAIT gives RUN on the next edge.
- Counter width is ceil(log2(max(HOLD_CYCLES, TIMEOUT_CYCLES)))+1 bits, with no wrap in use. The retry counter saturates.
- areset_i asserted mid-sequence, in any state, restarts the full sequence and clears timeout_o and the retry count.

Optional Feature:
- Macro: RST_SEQ_RELOCK_EN.
- Defined: in RUN with timeout_o=0, done_s=0 returns the FSM to HOLD.
  - Counter and retry count are cleared; net_rst_o=1, sys_rst_o=1, ready_o=0 after that edge.
  - The full sequence then re-runs.
  - RUN with timeout_o=1 is unaffected.
- Undefined: RUN is terminal until areset_i.

Test Plan (HOLD_CYCLES=16, TIMEOUT_CYCLES=64, MAX_RETRIES=2, SYNC_STAGES=3):
1. Nominal: areset_i pulse, net_resetdone_i raised before edge 25 -> net_rst_o falls after edge 19; sys_rst_o falls and ready_o rises after edge 28; state_o 0->1->2.
2. Early done: net_resetdone_i held 1 throughout -> net_rst_o falls after edge 19, sys_rst_o falls after edge 20; no shortcut of HOLD.
3. Timeout: net_resetdone_i held 0 -> three 64-cycle NET_WAIT windows separated by two 16-cycle net_rst_o re-assertions; then sys_rst_o=0, ready_o=1, timeout_o=1, state_o=2.
4. Mid-sequence reset: assert areset_i during retry 1 of NET_WAIT -> with no clock edge, net_rst_o=1, sys_rst_o=1, timeout_o=0, state_o=0; release reproduces scenario 1 timing.
5. Simultaneous done and timeout: done_s rises on the counter==63 cycle of the final attempt -> RUN with timeout_o=0.
6. Link drop in RUN: drop net_resetdone_i -> undefined macro: no output change for 200 cycles; RST_SEQ_RELOCK_EN: sys_rst_o and net_rst_o reassert 4 edges after the drop, then the sequence re-runs.
